// File: rtl/loc_bus_arb.sv
// Two-port arbiter/sequencer for the shared local bus: wins LHOLD/LHOLDA, runs one single-beat
// address+data cycle. Define LOC_ARB_FIXED_PRIO_EN to make port 0 always win ties.
module loc_bus_arb #(
  parameter int unsigned TMO_CYCLES = 255
) (
  input  logic        CLOCK,
  input  logic        RESETn,
  input  logic        REQ0,
  input  logic        REQ1,
  input  logic        WR0,
  input  logic        WR1,
  input  logic [31:0] ADDR0,
  input  logic [31:0] ADDR1,
  input  logic [31:0] WDATA0,
  input  logic [31:0] WDATA1,
  output logic        GNT0,
  output logic        GNT1,
  output logic        DONE0,
  output logic        DONE1,
  output logic        ERR0,
  output logic        ERR1,
  output logic [31:0] RDATA,
  output logic        LHOLD,
  input  logic        LHOLDA,
  output logic        ADSn,
  output logic        LW_Rn,
  input  logic        READYn,
  output logic [31:0] LAD_OUT,
  output logic        LAD_OE,
  input  logic [31:0] LAD_IN
);

  localparam logic [7:0] TmoLast = 8'(TMO_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StHold,
    StAddr,
    StData,
    StEnd
  } state_e;

  state_e      state;
  logic [7:0]  tmo_cnt;
  logic        sel;
  logic        wr_lat;
  logic [31:0] addr_lat;
  logic [31:0] wdata_lat;

  logic        pick;
  logic        tmo_hit;
  logic        fin_ok;
  logic        fin_err;

`ifdef LOC_ARB_FIXED_PRIO_EN
  always_comb begin
    pick = ~REQ0;
  end
`else
  logic last_win;

  // On a tie the loser of the previous grant wins; a lone request always wins.
  always_comb begin
    pick = REQ1;
    if (REQ0 && REQ1) begin
      pick = ~last_win;
    end
  end
`endif

  always_comb begin
    tmo_hit = (tmo_cnt == TmoLast);
    fin_ok  = (state == StData) && !READYn;
    fin_err = ((state == StHold) && !LHOLDA && tmo_hit) ||
              ((state == StData) && READYn && tmo_hit);
  end

  always_ff @(posedge CLOCK or negedge RESETn) begin
    if (!RESETn) begin
      state     <= StIdle;
      tmo_cnt   <= 8'd0;
      sel       <= 1'b0;
      wr_lat    <= 1'b0;
      addr_lat  <= 32'd0;
      wdata_lat <= 32'd0;
      GNT0      <= 1'b0;
      GNT1      <= 1'b0;
      DONE0     <= 1'b0;
      DONE1     <= 1'b0;
      ERR0      <= 1'b0;
      ERR1      <= 1'b0;
      RDATA     <= 32'd0;
      LHOLD     <= 1'b0;
      ADSn      <= 1'b1;
      LW_Rn     <= 1'b0;
      LAD_OUT   <= 32'd0;
      LAD_OE    <= 1'b0;
`ifndef LOC_ARB_FIXED_PRIO_EN
      last_win  <= 1'b1;
`endif
    end else begin
      DONE0 <= 1'b0;
      DONE1 <= 1'b0;
      ERR0  <= 1'b0;
      ERR1  <= 1'b0;
      if (fin_ok || fin_err) begin
        state   <= StEnd;
        tmo_cnt <= 8'd0;
        GNT0    <= 1'b0;
        GNT1    <= 1'b0;
        LHOLD   <= 1'b0;
        LAD_OE  <= 1'b0;
        DONE0   <= fin_ok && !sel;
        DONE1   <= fin_ok && sel;
        ERR0    <= fin_err && !sel;
        ERR1    <= fin_err && sel;
        if (fin_ok && !wr_lat) begin
          RDATA <= LAD_IN;
        end
      end else begin
        case (state)
          StIdle: begin
            if (REQ0 || REQ1) begin
              state     <= StHold;
              tmo_cnt   <= 8'd0;
              sel       <= pick;
              wr_lat    <= pick ? WR1 : WR0;
              addr_lat  <= pick ? ADDR1 : ADDR0;
              wdata_lat <= pick ? WDATA1 : WDATA0;
              GNT0      <= ~pick;
              GNT1      <= pick;
              LHOLD     <= 1'b1;
`ifndef LOC_ARB_FIXED_PRIO_EN
              last_win  <= pick;
`endif
            end
          end
          StHold: begin
            if (LHOLDA) begin
              state   <= StAddr;
              tmo_cnt <= 8'd0;
              ADSn    <= 1'b0;
              LAD_OE  <= 1'b1;
              LAD_OUT <= addr_lat;
              LW_Rn   <= wr_lat;
            end else begin
              tmo_cnt <= tmo_cnt + 8'd1;
            end
          end
          StAddr: begin
            state   <= StData;
            tmo_cnt <= 8'd0;
            ADSn    <= 1'b1;
            LAD_OE  <= wr_lat;
            if (wr_lat) begin
              LAD_OUT <= wdata_lat;
            end
          end
          StData: begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
          StEnd: begin
            state   <= StIdle;
            tmo_cnt <= 8'd0;
          end
          default: begin
            state <= StIdle;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_loc_bus_arb.sv
// Directed bench for loc_bus_arb: target model driven inline, completions checked against a
// scoreboard of expected {port, error, read data}.
module tb_loc_bus_arb;

  localparam int unsigned Tmo = 16;

  logic        CLOCK = 1'b0;
  logic        RESETn;
  logic        REQ0, REQ1, WR0, WR1;
  logic [31:0] ADDR0, ADDR1, WDATA0, WDATA1;
  logic        GNT0, GNT1, DONE0, DONE1, ERR0, ERR1;
  logic [31:0] RDATA;
  logic        LHOLD, LHOLDA, ADSn, LW_Rn, READYn, LAD_OE;
  logic [31:0] LAD_OUT, LAD_IN;

  loc_bus_arb #(.TMO_CYCLES(Tmo)) dut (
    .CLOCK(CLOCK), .RESETn(RESETn),
    .REQ0(REQ0), .REQ1(REQ1), .WR0(WR0), .WR1(WR1),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .GNT0(GNT0), .GNT1(GNT1), .DONE0(DONE0), .DONE1(DONE1), .ERR0(ERR0), .ERR1(ERR1),
    .RDATA(RDATA), .LHOLD(LHOLD), .LHOLDA(LHOLDA), .ADSn(ADSn), .LW_Rn(LW_Rn),
    .READYn(READYn), .LAD_OUT(LAD_OUT), .LAD_OE(LAD_OE), .LAD_IN(LAD_IN)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct packed {
    logic        port;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] rdata_model = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic sb_check();
    exp_t e;
    chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    chk("pulse_excl", 32'((DONE0 | DONE1) & (ERR0 | ERR1)), 32'd0);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("done_port", 32'(DONE1 | ERR1), 32'(e.port));
      chk("done_err", 32'(ERR0 | ERR1), 32'(e.err));
      chk("rdata", RDATA, e.rdata);
    end
  endtask

  task automatic chk_idle_reset_vals(input string tag);
    chk({tag, "_lhold"}, 32'(LHOLD), 32'd0);
    chk({tag, "_adsn"}, 32'(ADSn), 32'd1);
    chk({tag, "_lad_oe"}, 32'(LAD_OE), 32'd0);
    chk({tag, "_gnt"}, 32'({GNT1, GNT0}), 32'd0);
    chk({tag, "_pulses"}, 32'({DONE1, DONE0, ERR1, ERR0}), 32'd0);
  endtask

  // One transaction on port p; hold_dly/rdy_dly < 0 means the target never responds.
  task automatic do_txn(input int p, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdin,
                        input int hold_dly, input int rdy_dly, input bit exp_err,
                        input int rst_at, input int exp_lat);
    int  hold_cnt = 0;
    int  data_cnt = 0;
    int  ads_cnt = 0;
    bit  seen_addr = 0;
    bit  done = 0;
    exp_t e;
    if (rst_at == 0) begin
      if (!wr && !exp_err) rdata_model = rdin;
      e.port = p[0]; e.err = exp_err; e.rdata = rdata_model;
      sb.push_back(e);
    end
    if (p == 0) begin
      REQ0 = 1'b1; WR0 = wr; ADDR0 = addr; WDATA0 = wdata;
    end else begin
      REQ1 = 1'b1; WR1 = wr; ADDR1 = addr; WDATA1 = wdata;
    end
    LHOLDA = (hold_dly == 0);
    READYn = (rdy_dly != 0);
    LAD_IN = rdin;
    for (int cyc = 1; cyc <= 300 && !done; cyc++) begin
      @(negedge CLOCK);
      chk("gnt_onehot", 32'(GNT0 & GNT1), 32'd0);
      if (DONE0 | DONE1 | ERR0 | ERR1) begin
        sb_check();
        if (exp_lat > 0) chk("latency", 32'(cyc), 32'(exp_lat));
        chk("end_gnt", 32'({GNT1, GNT0}), 32'd0);
        chk("end_lhold", 32'(LHOLD), 32'd0);
        chk("end_oe", 32'(LAD_OE), 32'd0);
        if (exp_err && hold_dly < 0) begin
          chk("tmo_hold_clks", 32'(hold_cnt), 32'(Tmo));
          chk("tmo_no_ads", 32'(ads_cnt), 32'd0);
        end
        if (exp_err && rdy_dly < 0) chk("tmo_data_clks", 32'(data_cnt), 32'(Tmo));
        if (!exp_err) chk("data_clks", 32'(data_cnt), 32'((rdy_dly > 0) ? rdy_dly : 1));
        if (!exp_err) chk("ads_once", 32'(ads_cnt), 32'd1);
        REQ0 = 1'b0; REQ1 = 1'b0; LHOLDA = 1'b0; READYn = 1'b1;
        done = 1;
        @(negedge CLOCK);
        chk_idle_reset_vals("after_end");
      end else if (!ADSn) begin
        ads_cnt++;
        seen_addr = 1;
        chk("addr_lad", LAD_OUT, addr);
        chk("addr_oe", 32'(LAD_OE), 32'd1);
        chk("addr_lwrn", 32'(LW_Rn), 32'(wr));
        chk("addr_gnt", 32'({GNT1, GNT0}), (p == 0) ? 32'd1 : 32'd2);
      end else if (seen_addr && LHOLD) begin
        data_cnt++;
        chk("data_oe", 32'(LAD_OE), 32'(wr));
        chk("data_lwrn", 32'(LW_Rn), 32'(wr));
        if (wr) chk("data_lad", LAD_OUT, wdata);
        if (rst_at > 0 && data_cnt == rst_at) begin
          #2 RESETn = 1'b0;
          #1 chk_idle_reset_vals("async_rst");
          chk("async_rst_rdata", RDATA, 32'd0);
          REQ0 = 1'b0; REQ1 = 1'b0; LHOLDA = 1'b0; READYn = 1'b1;
          repeat (2) begin
            @(negedge CLOCK);
            chk("rst_no_pulse", 32'({DONE1, DONE0, ERR1, ERR0}), 32'd0);
          end
          RESETn = 1'b1;
          rdata_model = 32'd0;
          @(negedge CLOCK);
          chk_idle_reset_vals("post_rst");
          done = 1;
        end
        if (rdy_dly >= 0 && data_cnt >= rdy_dly) READYn = 1'b0;
      end else if (LHOLD && !seen_addr) begin
        hold_cnt++;
        if (hold_dly >= 0 && hold_cnt >= hold_dly) LHOLDA = 1'b1;
      end
    end
    chk("txn_done", 32'(done), 32'd1);
  endtask

  // Both ports request in the same clock; completions must come in first/second order.
  task automatic run_tie(input int first, input int second, input logic [31:0] rdin);
    exp_t e;
    int   ndone = 0;
    bit   prev_pulse = 0;
    rdata_model = rdin;
    e.err = 1'b0; e.rdata = rdin;
    e.port = first[0];  sb.push_back(e);
    e.port = second[0]; sb.push_back(e);
    REQ0 = 1'b1; REQ1 = 1'b1; WR0 = 1'b0; WR1 = 1'b0;
    ADDR0 = 32'h0000_0500; ADDR1 = 32'h0000_0600;
    LHOLDA = 1'b1; READYn = 1'b0; LAD_IN = rdin;
    for (int cyc = 1; cyc <= 100 && ndone < 2; cyc++) begin
      @(negedge CLOCK);
      chk("tie_onehot", 32'(GNT0 & GNT1), 32'd0);
      if (prev_pulse) chk("tie_gap_lhold", 32'(LHOLD), 32'd0);
      prev_pulse = 0;
      if (DONE0 | DONE1 | ERR0 | ERR1) begin
        sb_check();
        if (DONE0) REQ0 = 1'b0;
        if (DONE1) REQ1 = 1'b0;
        ndone++;
        prev_pulse = 1;
      end
    end
    chk("tie_done", 32'(ndone), 32'd2);
    REQ0 = 1'b0; REQ1 = 1'b0; LHOLDA = 1'b0; READYn = 1'b1;
    @(negedge CLOCK);
    chk_idle_reset_vals("tie_after");
  endtask

  initial begin
    RESETn = 1'b0;
    REQ0 = 1'b0; REQ1 = 1'b0; WR0 = 1'b0; WR1 = 1'b0;
    ADDR0 = 32'd0; ADDR1 = 32'd0; WDATA0 = 32'd0; WDATA1 = 32'd0;
    LHOLDA = 1'b0; READYn = 1'b1; LAD_IN = 32'd0;
    repeat (2) @(negedge CLOCK);
    chk_idle_reset_vals("reset");
    chk("reset_lwrn", 32'(LW_Rn), 32'd0);
    chk("reset_lad_out", LAD_OUT, 32'd0);
    chk("reset_rdata", RDATA, 32'd0);
    RESETn = 1'b1;
    @(negedge CLOCK);
    chk_idle_reset_vals("idle");

    do_txn(0, 1'b0, 32'h0000_0040, 32'd0, 32'hCAFE_0001, 0, 0, 1'b0, 0, 4);
    do_txn(1, 1'b1, 32'h0000_0100, 32'h1234_5678, 32'hDEAD_BEEF, 0, 3, 1'b0, 0, 0);
    run_tie(0, 1, 32'h5555_AAAA);
    do_txn(0, 1'b0, 32'h0000_0200, 32'd0, 32'h0000_1111, -1, 0, 1'b1, 0, 0);
`ifdef LOC_ARB_FIXED_PRIO_EN
    run_tie(0, 1, 32'h3C3C_0F0F);
`else
    run_tie(1, 0, 32'h3C3C_0F0F);
`endif
    do_txn(1, 1'b0, 32'h0000_0300, 32'd0, 32'h0000_2222, 0, -1, 1'b1, 0, 0);
    do_txn(0, 1'b1, 32'h0000_0400, 32'hA5A5_5A5A, 32'd0, 0, -1, 1'b0, 2, 0);
    run_tie(0, 1, 32'h7777_0000);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
